// File: rtl/mc_control_fsm.sv
// mc_control_fsm
//   Multi-cycle control sequencer for the 64-bit RISC-V datapath. It walks
//   each instruction through fetch, decode, execute, memory and writeback.
//   In each state it drives the datapath mux selects, the register and
//   memory enables, and the 4-bit ALU operation code. It also owns the
//   request/ready handshake to the unified instruction/data memory.
//
//   Build option: ILLEGAL_TRAP_EN
//     defined   - ILLEGAL is terminal; only rst leaves it.
//     undefined - ILLEGAL lasts one cycle, then the FSM returns to FETCH.
//
//   Ports
//     clk        rising-edge clock
//     rst        asynchronous active-high reset
//     opcode     IR[6:0], stable from DECODE until the next FETCH
//     funct3     IR[14:12]
//     funct7_5   IR[30]
//     zero       ALU zero flag
//     mem_ready  memory completes the current request this cycle
//     mem_req    memory request
//     mem_we     write request (meaningful only with mem_req)
//     i_or_d     address select: 0 = PC, 1 = ALU-out register
//     ir_write   load IR
//     pc_write   load PC
//     pc_src     PC source: 0 = ALU result, 1 = target register
//     tgt_write  load target register from the ALU result
//     reg_write  register-file write
//     wb_sel     writeback source: 00 = ALU-out, 01 = MDR, 10 = PC
//     alu_src_a  ALU A source: 0 = PC, 1 = A register
//     alu_src_b  ALU B source: 00 = B register, 01 = constant 4, 10 = imm
//     alu_ctrl   ALU operation code
//     illegal    unsupported instruction seen
module mc_control_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic       tgt_write,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_ctrl,
    output logic       illegal
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_TGT = 4'b1000;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_MEM_ADDR,
        S_MEM_RD,
        S_LOAD_WB,
        S_MEM_WR,
        S_BRANCH,
        S_JAL,
        S_ILLEGAL
    } state_t;

    state_t state, next_state;

    // funct3 -> ALU code for R/I arithmetic; sub selects SUB on funct3 000
    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  arith_op = sub ? ALU_SUB : ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b101:  arith_op = ALU_SRL;
            3'b010:  arith_op = ALU_SLT;
            3'b110:  arith_op = ALU_OR;
            3'b111:  arith_op = ALU_AND;
            default: arith_op = ALU_ADD;
        endcase
    endfunction

    function automatic logic arith_f3_ok(input logic [2:0] f3);
        arith_f3_ok = (f3 != 3'b011) && (f3 != 3'b100);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        tgt_write  = 1'b0;
        reg_write  = 1'b0;
        wb_sel     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_ctrl   = ALU_ADD;
        illegal    = 1'b0;

        // Outputs are gated by rst itself so a pending request or write
        // enable drops the moment reset rises, not at the next edge.
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'b01;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        next_state = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_src_b = 2'b10;
                    alu_ctrl  = ALU_TGT;
                    tgt_write = 1'b1;
                    case (opcode)
                        OP_R:               next_state = S_EXEC_R;
                        OP_I:               next_state = S_EXEC_I;
                        OP_LOAD, OP_STORE:  next_state = S_MEM_ADDR;
                        OP_BRANCH:          next_state = S_BRANCH;
                        OP_JAL:             next_state = S_JAL;
                        default:            next_state = S_ILLEGAL;
                    endcase
                end
                S_EXEC_R: begin
                    alu_src_a  = 1'b1;
                    alu_ctrl   = arith_op(funct3, funct7_5);
                    next_state = arith_f3_ok(funct3) ? S_ALU_WB : S_ILLEGAL;
                end
                S_EXEC_I: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = 2'b10;
                    alu_ctrl   = arith_op(funct3, 1'b0);
                    next_state = arith_f3_ok(funct3) ? S_ALU_WB : S_ILLEGAL;
                end
                S_ALU_WB: begin
                    reg_write  = 1'b1;
                    next_state = S_FETCH;
                end
                S_MEM_ADDR: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = 2'b10;
                    next_state = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
                end
                S_MEM_RD: begin
                    mem_req = 1'b1;
                    i_or_d  = 1'b1;
                    if (mem_ready) next_state = S_LOAD_WB;
                end
                S_LOAD_WB: begin
                    reg_write  = 1'b1;
                    wb_sel     = 2'b01;
                    next_state = S_FETCH;
                end
                S_MEM_WR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    i_or_d  = 1'b1;
                    if (mem_ready) next_state = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_ctrl  = ALU_SUB;
                    pc_src    = 1'b1;
                    // beq/bne only; any other compare never redirects the PC
                    if (funct3[2:1] == 2'b00) begin
                        pc_write   = zero ^ funct3[0];
                        next_state = S_FETCH;
                    end else begin
                        next_state = S_ILLEGAL;
                    end
                end
                S_JAL: begin
                    reg_write  = 1'b1;
                    wb_sel     = 2'b10;
                    pc_write   = 1'b1;
                    pc_src     = 1'b1;
                    next_state = S_FETCH;
                end
                S_ILLEGAL: begin
                    illegal = 1'b1;
`ifdef ILLEGAL_TRAP_EN
                    next_state = S_ILLEGAL;
`else
                    // PC already advanced in FETCH, so this acts as a NOP
                    next_state = S_FETCH;
`endif
                end
                default: next_state = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm
//   Directed bench for mc_control_fsm. Each instruction is expanded into a
//   plan of per-cycle steps (inputs to drive plus the outputs the sequencer
//   must show that cycle) from the instruction-level rules; a driver plays
//   the plan and one compare process checks every cycle on the falling edge.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src;
    logic       tgt_write, reg_write, alu_src_a, illegal;
    logic [1:0] wb_sel, alu_src_b;
    logic [3:0] alu_ctrl;

    mc_control_fsm dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .tgt_write(tgt_write), .reg_write(reg_write), .wb_sel(wb_sel),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       tgt_write;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_ctrl;
        logic       illegal;
    } outv_t;

    typedef struct packed {
        logic       rst;
        logic       mem_ready;
        logic       zero;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f75;
        outv_t      exp;
    } step_t;

    step_t plan[$];
    outv_t exp_q[$];
    outv_t got;
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;

    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    logic       cur_f75;
    logic       cur_z;

    assign got = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src,
                  tgt_write, reg_write, wb_sel, alu_src_a, alu_src_b,
                  alu_ctrl, illegal};

    // quiet output set: no enables, selects 0, ADD
    function automatic outv_t quiet();
        outv_t o;
        o = '0;
        o.alu_ctrl = 4'b0010;
        return o;
    endfunction

    function automatic logic [3:0] alu_code(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  return sub ? 4'b0110 : 4'b0010;
            3'b001:  return 4'b0011;
            3'b101:  return 4'b0100;
            3'b010:  return 4'b0111;
            3'b110:  return 4'b0001;
            3'b111:  return 4'b0000;
            default: return 4'b0010;
        endcase
    endfunction

    task automatic push(input logic r, input logic mr, input outv_t e);
        step_t s;
        s.rst = r; s.mem_ready = mr; s.zero = cur_z;
        s.op = cur_op; s.f3 = cur_f3; s.f75 = cur_f75; s.exp = e;
        plan.push_back(s);
    endtask

    task automatic reset_steps(input int n);
        for (int i = 0; i < n; i++) push(1'b1, 1'b0, quiet());
    endtask

    task automatic illegal_tail();
        outv_t e;
        e = quiet();
        e.illegal = 1'b1;
        push(1'b0, 1'b1, e);
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 9; i++) push(1'b0, 1'b1, e);
        reset_steps(2);
`endif
    endtask

    // Expand one instruction into its cycle plan. fs/ms are stall counts in
    // FETCH and in the data-memory wait; abort leaves the data access pending.
    task automatic model_instr(input logic [6:0] op, input logic [2:0] f3,
                               input logic f75, input logic z, input int fs,
                               input int ms, input bit abort, output int n);
        outv_t e;
        int    start;
        bit    rtype;
        start = plan.size();
        cur_op = op; cur_f3 = f3; cur_f75 = f75; cur_z = z;

        e = quiet(); e.mem_req = 1'b1; e.alu_src_b = 2'b01;
        for (int i = 0; i < fs; i++) push(1'b0, 1'b0, e);
        e.ir_write = 1'b1; e.pc_write = 1'b1;
        push(1'b0, 1'b1, e);

        e = quiet(); e.alu_src_b = 2'b10; e.alu_ctrl = 4'b1000; e.tgt_write = 1'b1;
        push(1'b0, 1'b1, e);

        case (op)
            7'b0110011, 7'b0010011: begin
                rtype = (op == 7'b0110011);
                e = quiet(); e.alu_src_a = 1'b1;
                e.alu_src_b = rtype ? 2'b00 : 2'b10;
                e.alu_ctrl = alu_code(f3, rtype ? f75 : 1'b0);
                push(1'b0, 1'b1, e);
                if (f3 == 3'b011 || f3 == 3'b100) begin
                    illegal_tail();
                end else begin
                    e = quiet(); e.reg_write = 1'b1;
                    push(1'b0, 1'b1, e);
                end
            end
            7'b0000011, 7'b0100011: begin
                e = quiet(); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
                push(1'b0, 1'b1, e);
                e = quiet(); e.mem_req = 1'b1; e.i_or_d = 1'b1;
                e.mem_we = (op == 7'b0100011);
                for (int i = 0; i < ms; i++) push(1'b0, 1'b0, e);
                if (!abort) begin
                    push(1'b0, 1'b1, e);
                    if (op == 7'b0000011) begin
                        e = quiet(); e.reg_write = 1'b1; e.wb_sel = 2'b01;
                        push(1'b0, 1'b1, e);
                    end
                end
            end
            7'b1100011: begin
                e = quiet(); e.alu_src_a = 1'b1; e.alu_ctrl = 4'b0110; e.pc_src = 1'b1;
                if (f3 == 3'b000 || f3 == 3'b001) begin
                    e.pc_write = z ^ f3[0];
                    push(1'b0, 1'b1, e);
                end else begin
                    push(1'b0, 1'b1, e);
                    illegal_tail();
                end
            end
            7'b1101111: begin
                e = quiet(); e.reg_write = 1'b1; e.wb_sel = 2'b10;
                e.pc_write = 1'b1; e.pc_src = 1'b1;
                push(1'b0, 1'b1, e);
            end
            default: illegal_tail();
        endcase
        n = plan.size() - start;
    endtask

    task automatic pin(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            outv_t e;
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL cycle%0d outputs actual %h required %h", cyc, got, e);
            end
            cyc++;
        end
    end

    initial begin
        int n;
        step_t s;
        rst = 1'b0; opcode = '0; funct3 = '0; funct7_5 = 1'b0;
        zero = 1'b0; mem_ready = 1'b0;
        cur_op = '0; cur_f3 = '0; cur_f75 = 1'b0; cur_z = 1'b0;
        #2 rst = 1'b1;

        // literal anchors for the model's ALU table
        pin("code_sub", int'(alu_code(3'b000, 1'b1)), 6);
        pin("code_slt", int'(alu_code(3'b010, 1'b0)), 7);
        pin("code_and", int'(alu_code(3'b111, 1'b0)), 0);

        reset_steps(2);
        model_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0, 1'b0, n);
        pin("add_cpi", n, 4);
        model_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0, 1'b0, n);
        pin("addi_cpi", n, 4);
        model_instr(7'b0010011, 3'b001, 1'b0, 1'b0, 1, 0, 1'b0, n);
        pin("slli_stall_cpi", n, 5);
        model_instr(7'b0010011, 3'b110, 1'b0, 1'b0, 0, 0, 1'b0, n);
        model_instr(7'b0110011, 3'b001, 1'b0, 1'b0, 0, 0, 1'b0, n);
        model_instr(7'b0110011, 3'b101, 1'b0, 1'b0, 0, 0, 1'b0, n);
        model_instr(7'b0110011, 3'b010, 1'b0, 1'b0, 0, 0, 1'b0, n);
        model_instr(7'b0110011, 3'b111, 1'b0, 1'b0, 0, 0, 1'b0, n);
        model_instr(7'b0110011, 3'b110, 1'b0, 1'b0, 0, 0, 1'b0, n);
        model_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0, n);
        model_instr(7'b0000011, 3'b011, 1'b0, 1'b0, 0, 0, 1'b0, n);
        pin("load_cpi", n, 5);
        model_instr(7'b0000011, 3'b011, 1'b0, 1'b0, 0, 3, 1'b0, n);
        pin("load_stall_cpi", n, 8);
        model_instr(7'b0100011, 3'b011, 1'b0, 1'b0, 0, 0, 1'b0, n);
        pin("store_cpi", n, 4);
        model_instr(7'b0100011, 3'b011, 1'b0, 1'b0, 0, 2, 1'b0, n);
        model_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0, 1'b0, n);
        pin("beq_cpi", n, 3);
        model_instr(7'b1100011, 3'b001, 1'b0, 1'b1, 0, 0, 1'b0, n);
        model_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0, n);
        model_instr(7'b1100011, 3'b001, 1'b0, 1'b0, 0, 0, 1'b0, n);
        model_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0, n);
        pin("jal_cpi", n, 3);
        model_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0, n);
        model_instr(7'b0110011, 3'b011, 1'b0, 1'b0, 0, 0, 1'b0, n);
        model_instr(7'b0010011, 3'b100, 1'b0, 1'b0, 0, 0, 1'b0, n);
        model_instr(7'b1100011, 3'b100, 1'b0, 1'b1, 0, 0, 1'b0, n);
        // store stalled twice, then reset lands while the write is pending
        model_instr(7'b0100011, 3'b011, 1'b0, 1'b0, 0, 2, 1'b1, n);
        reset_steps(2);
        model_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0, 1'b0, n);

        while (plan.size() > 0) begin
            s = plan.pop_front();
            @(posedge clk);
            #1;
            rst = s.rst; mem_ready = s.mem_ready; zero = s.zero;
            opcode = s.op; funct3 = s.f3; funct7_5 = s.f75;
            exp_q.push_back(s.exp);
        end
        @(negedge clk);
        #1;
        pin("drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
